// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetch (T0-T2) followed by
// three-register ALU execution, with two-step HI/LO writeback for multiply/divide.
module alu_op_sequencer #(
    parameter int OPC_W   = 5,
    parameter int REG_W   = 4,
    parameter int CTRL_W  = 5,
    parameter int OPC_MIN = 3,
    parameter int OPC_MAX = 16,
    parameter int MUL_OPC = 15,
    parameter int DIV_OPC = 16
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Run,
    input  logic [31:0]           IR,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [3:0]            State,
    output logic                  PC_Out,
    output logic                  PC_In,
    output logic                  MAR_In,
    output logic                  MDR_In,
    output logic                  MDR_Out,
    output logic                  IR_In,
    output logic                  Y_In,
    output logic                  IncPC,
    output logic                  Read,
    output logic                  ZLO_In,
    output logic                  ZHI_In,
    output logic                  ZLO_Out,
    output logic                  ZHI_Out,
    output logic                  LO_In,
    output logic                  HI_In,
    output logic [2**REG_W-1:0]   R_Out,
    output logic [2**REG_W-1:0]   R_In,
    output logic [CTRL_W-1:0]     CONTROL
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        DONE = 4'd8
    } state_t;

    localparam int RA_HI = 31 - OPC_W;
    localparam int RB_HI = RA_HI - REG_W;
    localparam int RC_HI = RB_HI - REG_W;

    localparam logic [OPC_W-1:0]  OPC_MIN_L = OPC_W'(OPC_MIN);
    localparam logic [OPC_W-1:0]  OPC_MAX_L = OPC_W'(OPC_MAX);
    localparam logic [OPC_W-1:0]  MUL_L     = OPC_W'(MUL_OPC);
    localparam logic [OPC_W-1:0]  DIV_L     = OPC_W'(DIV_OPC);
    localparam logic [CTRL_W-1:0] CTRL_BIAS = CTRL_W'(OPC_MIN);

    state_t state_q, state_d;
    logic   err_q, err_d;

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra, rb, rc;
    logic             legal, muldiv;

    assign opcode = IR[31 -: OPC_W];
    assign ra     = IR[RA_HI -: REG_W];
    assign rb     = IR[RB_HI -: REG_W];
    assign rc     = IR[RC_HI -: REG_W];
    assign legal  = (opcode >= OPC_MIN_L) && (opcode <= OPC_MAX_L);
    assign muldiv = (opcode == MUL_L) || (opcode == DIV_L);

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (Run) state_d = T0;
            T0:   state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
            T3: begin
                if (legal) begin
                    state_d = T4;
                end else begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            T4:   state_d = T5;
            T5:   state_d = muldiv ? T6 : DONE;
            T6:   state_d = DONE;
            DONE: state_d = Run ? T0 : IDLE;
            default: state_d = IDLE;
        endcase
        // Err is sticky across DONE/IDLE and only drops when a new fetch begins.
        if (state_d == T0) err_d = 1'b0;
    end

    always_comb begin
        PC_Out  = 1'b0;
        PC_In   = 1'b0;
        MAR_In  = 1'b0;
        MDR_In  = 1'b0;
        MDR_Out = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ZLO_In  = 1'b0;
        ZHI_In  = 1'b0;
        ZLO_Out = 1'b0;
        ZHI_Out = 1'b0;
        LO_In   = 1'b0;
        HI_In   = 1'b0;
        R_Out   = '0;
        R_In    = '0;
        CONTROL = '0;
        Err     = err_q;
        State   = state_q;
        Busy    = (state_q != IDLE);
        Done    = (state_q == DONE);
        case (state_q)
            T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
                ZLO_In = 1'b1;
            end
            T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
            end
            T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            // An illegal opcode raises Err here already, before the sticky flop catches it.
            T3: begin
                if (legal) begin
                    R_Out[rb] = 1'b1;
                    Y_In      = 1'b1;
                end else begin
                    Err = 1'b1;
                end
            end
            T4: begin
                R_Out[rc] = 1'b1;
                CONTROL   = CTRL_W'(opcode) - CTRL_BIAS;
                ZLO_In    = 1'b1;
                ZHI_In    = muldiv;
            end
            T5: begin
                ZLO_Out = 1'b1;
                if (muldiv) LO_In = 1'b1;
                else        R_In[ra] = 1'b1;
            end
            T6: begin
                ZHI_Out = 1'b1;
                HI_In   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus queues hand-computed per-cycle strobe
// records, a negedge monitor pops one per cycle and compares every output.
module tb_alu_op_sequencer;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    // Strobe vector order: PC_Out PC_In MAR_In MDR_In MDR_Out IR_In Y_In IncPC Read
    // ZLO_In ZHI_In ZLO_Out ZHI_Out LO_In HI_In (bit 14 down to bit 0).
    localparam logic [14:0] ST_T0   = 15'h50A0;
    localparam logic [14:0] ST_T1   = 15'h2848;
    localparam logic [14:0] ST_T2   = 15'h0600;
    localparam logic [14:0] Y_IN    = 15'h0100;
    localparam logic [14:0] ZLO_IN  = 15'h0020;
    localparam logic [14:0] ZHI_IN  = 15'h0010;
    localparam logic [14:0] ZLO_OUT = 15'h0008;
    localparam logic [14:0] ZHI_OUT = 15'h0004;
    localparam logic [14:0] LO_IN   = 15'h0002;
    localparam logic [14:0] HI_IN   = 15'h0001;

    localparam int K_ALU = 0;
    localparam int K_MD  = 1;
    localparam int K_ILL = 2;

    typedef struct {
        logic [3:0]  state;
        logic        busy;
        logic        done;
        logic        err;
        logic [14:0] strobes;
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic [4:0]  control;
        string       name;
    } exp_t;

    logic        Clock, Clear, Run;
    logic [31:0] IR;
    logic        Busy, Done, Err;
    logic [3:0]  State;
    logic        PC_Out, PC_In, MAR_In, MDR_In, MDR_Out, IR_In, Y_In, IncPC, Read;
    logic        ZLO_In, ZHI_In, ZLO_Out, ZHI_Out, LO_In, HI_In;
    logic [15:0] R_Out, R_In;
    logic [4:0]  CONTROL;
    logic [14:0] dut_strobes;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic idle_err     = 1'b0;

    alu_op_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
        .Busy(Busy), .Done(Done), .Err(Err), .State(State),
        .PC_Out(PC_Out), .PC_In(PC_In), .MAR_In(MAR_In), .MDR_In(MDR_In),
        .MDR_Out(MDR_Out), .IR_In(IR_In), .Y_In(Y_In), .IncPC(IncPC), .Read(Read),
        .ZLO_In(ZLO_In), .ZHI_In(ZHI_In), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
        .LO_In(LO_In), .HI_In(HI_In), .R_Out(R_Out), .R_In(R_In), .CONTROL(CONTROL)
    );

    assign dut_strobes = {PC_Out, PC_In, MAR_In, MDR_In, MDR_Out, IR_In, Y_In, IncPC, Read,
                          ZLO_In, ZHI_In, ZLO_Out, ZHI_Out, LO_In, HI_In};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic pushCycle(input logic [3:0] st, input logic dn, input logic er,
                             input logic [14:0] stb, input logic [15:0] ro,
                             input logic [15:0] ri, input logic [4:0] ctl, input string nm);
        exp_t e;
        e.state   = st;
        e.busy    = (st != S_IDLE);
        e.done    = dn;
        e.err     = er;
        e.strobes = stb;
        e.r_out   = ro;
        e.r_in    = ri;
        e.control = ctl;
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    task automatic pushInstr(input int kind, input logic [15:0] ro3, input logic [15:0] ro4,
                             input logic [15:0] ri5, input logic [4:0] ctl,
                             input bit lead, input bit trail, input string nm);
        if (lead) pushCycle(S_IDLE, 1'b0, idle_err, '0, '0, '0, '0, {nm, " idle"});
        pushCycle(S_T0, 1'b0, 1'b0, ST_T0, '0, '0, '0, {nm, " T0"});
        pushCycle(S_T1, 1'b0, 1'b0, ST_T1, '0, '0, '0, {nm, " T1"});
        pushCycle(S_T2, 1'b0, 1'b0, ST_T2, '0, '0, '0, {nm, " T2"});
        if (kind == K_ILL) begin
            pushCycle(S_T3, 1'b0, 1'b1, '0, '0, '0, '0, {nm, " T3"});
            pushCycle(S_DONE, 1'b1, 1'b1, '0, '0, '0, '0, {nm, " DONE"});
            idle_err = 1'b1;
        end else begin
            pushCycle(S_T3, 1'b0, 1'b0, Y_IN, ro3, '0, '0, {nm, " T3"});
            if (kind == K_MD) begin
                pushCycle(S_T4, 1'b0, 1'b0, ZLO_IN | ZHI_IN, ro4, '0, ctl, {nm, " T4"});
                pushCycle(S_T5, 1'b0, 1'b0, ZLO_OUT | LO_IN, '0, '0, '0, {nm, " T5"});
                pushCycle(S_T6, 1'b0, 1'b0, ZHI_OUT | HI_IN, '0, '0, '0, {nm, " T6"});
            end else begin
                pushCycle(S_T4, 1'b0, 1'b0, ZLO_IN, ro4, '0, ctl, {nm, " T4"});
                pushCycle(S_T5, 1'b0, 1'b0, ZLO_OUT, '0, ri5, '0, {nm, " T5"});
            end
            pushCycle(S_DONE, 1'b1, 1'b0, '0, '0, '0, '0, {nm, " DONE"});
            idle_err = 1'b0;
        end
        if (trail) pushCycle(S_IDLE, 1'b0, idle_err, '0, '0, '0, '0, {nm, " after"});
    endtask

    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (State !== e.state || Busy !== e.busy || Done !== e.done || Err !== e.err ||
            dut_strobes !== e.strobes || R_Out !== e.r_out || R_In !== e.r_in ||
            CONTROL !== e.control) begin
            tests_failed++;
            $display("[TB] FAIL %s: got state=%0d busy=%b done=%b err=%b strobes=%h rout=%h rin=%h ctrl=%h, expected state=%0d busy=%b done=%b err=%b strobes=%h rout=%h rin=%h ctrl=%h",
                     e.name, State, Busy, Done, Err, dut_strobes, R_Out, R_In, CONTROL,
                     e.state, e.busy, e.done, e.err, e.strobes, e.r_out, e.r_in, e.control);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end else if (Busy === 1'b1 || Done === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected activity: got state=%0d busy=%b done=%b, expected idle",
                     State, Busy, Done);
        end
    end

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge Clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain timeout: got %0d records pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input int kind, input logic [15:0] ro3,
                                 input logic [15:0] ro4, input logic [15:0] ri5,
                                 input logic [4:0] ctl, input string nm);
        IR  = ir;
        Run = 1'b1;
        pushInstr(kind, ro3, ro4, ri5, ctl, 1'b1, 1'b1, nm);
        @(posedge Clock);
        #1;
        Run = 1'b0;
        waitDrain(20);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Clear = 1'b0;
        Run   = 1'b0;
        IR    = '0;
        @(posedge Clock);
        #1;
        pushCycle(S_IDLE, 1'b0, 1'b0, '0, '0, '0, '0, "reset");
        @(posedge Clock);
        #1;
        Clear = 1'b1;
        waitDrain(4);

        applyStimulus(32'h2292_0000, K_ALU, 16'h0004, 16'h0010, 16'h0020, 5'd1,  "sub");
        applyStimulus(32'h7812_0000, K_MD,  16'h0004, 16'h0010, 16'h0000, 5'd12, "mul");
        applyStimulus(32'hF800_0000, K_ILL, '0, '0, '0, '0, "ill31");
        applyStimulus(32'h1A92_0000, K_ALU, 16'h0004, 16'h0010, 16'h0020, 5'd0,  "add");
        applyStimulus(32'h8099_8000, K_MD,  16'h0008, 16'h0008, 16'h0000, 5'd13, "div");
        applyStimulus(32'h73B8_0000, K_ALU, 16'h0080, 16'h0001, 16'h0080, 5'd11, "op14");
        applyStimulus(32'h8800_0000, K_ILL, '0, '0, '0, '0, "ill17");
        applyStimulus(32'h1000_0000, K_ILL, '0, '0, '0, '0, "ill2");

        // Sticky Err must be wiped by Clear even though no T0 follows.
        Clear = 1'b0;
        pushCycle(S_IDLE, 1'b0, 1'b1, '0, '0, '0, '0, "err sticky");
        pushCycle(S_IDLE, 1'b0, 1'b0, '0, '0, '0, '0, "err reset");
        @(posedge Clock);
        #1;
        Clear    = 1'b1;
        idle_err = 1'b0;
        waitDrain(4);

        IR  = 32'h1A92_0000;
        Run = 1'b1;
        pushInstr(K_ALU, 16'h0004, 16'h0010, 16'h0020, 5'd0, 1'b1, 1'b0, "b2b add");
        pushInstr(K_ALU, 16'h0004, 16'h0010, 16'h0020, 5'd1, 1'b0, 1'b1, "b2b sub");
        repeat (8) @(posedge Clock);
        #1;
        IR = 32'h2292_0000;
        @(posedge Clock);
        #1;
        Run = 1'b0;
        waitDrain(30);

        IR  = 32'h2292_0000;
        Run = 1'b1;
        pushCycle(S_IDLE, 1'b0, 1'b0, '0, '0, '0, '0, "midrst idle");
        pushCycle(S_T0, 1'b0, 1'b0, ST_T0, '0, '0, '0, "midrst T0");
        pushCycle(S_T1, 1'b0, 1'b0, ST_T1, '0, '0, '0, "midrst T1");
        pushCycle(S_T2, 1'b0, 1'b0, ST_T2, '0, '0, '0, "midrst T2");
        pushCycle(S_T3, 1'b0, 1'b0, Y_IN, 16'h0004, '0, '0, "midrst T3");
        pushCycle(S_T4, 1'b0, 1'b0, ZLO_IN, 16'h0010, '0, 5'd1, "midrst T4");
        pushCycle(S_IDLE, 1'b0, 1'b0, '0, '0, '0, '0, "midrst cleared");
        pushCycle(S_IDLE, 1'b0, 1'b0, '0, '0, '0, '0, "midrst stays idle");
        @(posedge Clock);
        #1;
        Run = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        Clear = 1'b0;
        @(posedge Clock);
        #1;
        Clear = 1'b1;
        waitDrain(10);

        applyStimulus(32'h2292_0000, K_ALU, 16'h0004, 16'h0010, 16'h0020, 5'd1, "sub again");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
